// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the 16-bit pipelined CPU. One shared single-port
// asynchronous SRAM answers both the instruction-fetch port (B) and the data
// port (A). When both ports want the SRAM in the same cycle, a two-state FSM
// gives the cycle to A and freezes the pipeline with stall_o. B then gets the
// SRAM in the following cycle.
//
// The block also decodes a two-register UART MMIO window:
//   MMIO_DATA : read returns the received byte; write sends a byte
//   MMIO_STAT : read returns {overrun, rxFull, txReady}
// It raises irq_o while a received byte is waiting to be read.
//
// Ports
//   clk_i, rst_i             clock; synchronous active-high reset
//   a_addr_i, a_wdata_i      data port word address / write data
//   a_ctrl_i                 00 idle, 01 read, 10 write, 11 idle
//   a_rdata_o                data port read data (registered)
//   b_addr_i                 fetch address, presented every cycle
//   b_rdata_o                fetched instruction (registered)
//   stall_o                  CPU must hold its pipeline and requests
//   sram_*                   asynchronous SRAM bus; strobes are active-low
//   uart_tx_*                transmit byte, one-cycle strobe, ready input
//   uart_rx_*                received byte and one-cycle strobe
//   irq_o, irq_index_o       interrupt request and its fixed index
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter logic [15:0] MMIO_DATA    = 16'hBF00,
    parameter logic [15:0] MMIO_STAT    = 16'hBF01,
    parameter logic [3:0]  RX_IRQ_INDEX = 4'h3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] a_addr_i,
    input  logic [15:0] a_wdata_i,
    input  logic [1:0]  a_ctrl_i,
    output logic [15:0] a_rdata_o,
    input  logic [15:0] b_addr_i,
    output logic [15:0] b_rdata_o,
    output logic        stall_o,
    output logic [15:0] sram_addr_o,
    output logic [15:0] sram_wdata_o,
    input  logic [15:0] sram_rdata_i,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [7:0]  uart_tx_data_o,
    output logic        uart_tx_valid_o,
    input  logic        uart_tx_ready_i,
    input  logic [7:0]  uart_rx_data_i,
    input  logic        uart_rx_valid_i,
    output logic        irq_o,
    output logic [3:0]  irq_index_o
);

    typedef enum logic {
        FETCH     = 1'b0,
        DATA_DONE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] aRdata_q, aRdata_d;
    logic [15:0] bRdata_q, bRdata_d;
    logic        txValid_q, txValid_d;
    logic [7:0]  txData_q, txData_d;
    logic [7:0]  rxBuf_q, rxBuf_d;
    logic        rxFull_q, rxFull_d;
    logic        overrun_q, overrun_d;

    logic aIsRead;
    logic aIsWrite;
    logic aIsMmio;
    logic aSramReq;
    logic serveA;
    logic mmioRdData;
    logic mmioRdStat;
    logic mmioWrData;

    // Request decode. Only reads and writes outside the MMIO window compete
    // for the SRAM; MMIO accesses are served from registers alongside a fetch.
    assign aIsRead  = (a_ctrl_i == 2'b01);
    assign aIsWrite = (a_ctrl_i == 2'b10);
    assign aIsMmio  = (a_addr_i == MMIO_DATA) || (a_addr_i == MMIO_STAT);
    assign aSramReq = (aIsRead || aIsWrite) && !aIsMmio;

    // MMIO side effects only fire in FETCH. In DATA_DONE the CPU is still
    // showing the SRAM request that was just served, so it must be ignored.
    // A held MMIO request never stalls, so each cycle is a fresh access.
    assign mmioRdData = (state_q == FETCH) && aIsRead  && (a_addr_i == MMIO_DATA);
    assign mmioRdStat = (state_q == FETCH) && aIsRead  && (a_addr_i == MMIO_STAT);
    assign mmioWrData = (state_q == FETCH) && aIsWrite && (a_addr_i == MMIO_DATA);

    // Arbitration FSM and SRAM bus drive. Everything here is combinational,
    // so a write strobe covers the whole cycle and drops the moment reset is
    // raised. The SRAM is deselected with all strobes high while in reset.
    always_comb begin
        state_d     = FETCH;
        stall_o     = 1'b0;
        serveA      = 1'b0;
        sram_ce_n_o = 1'b1;
        sram_oe_n_o = 1'b1;
        sram_we_n_o = 1'b1;
        sram_addr_o = b_addr_i;
        if (!rst_i) begin
            sram_ce_n_o = 1'b0;
            case (state_q)
                FETCH: begin
                    if (aSramReq) begin
                        serveA      = 1'b1;
                        stall_o     = 1'b1;
                        sram_addr_o = a_addr_i;
                        sram_oe_n_o = !aIsRead;
                        sram_we_n_o = !aIsWrite;
                        state_d     = DATA_DONE;
                    end else begin
                        sram_oe_n_o = 1'b0;
                        state_d     = FETCH;
                    end
                end
                DATA_DONE: begin
                    sram_oe_n_o = 1'b0;
                    state_d     = FETCH;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign sram_wdata_o = a_wdata_i;

    // Read-data capture. Whichever port owned the SRAM this cycle latches
    // sram_rdata_i; the other port keeps its last value. MMIO reads load the
    // A register from the UART state instead.
    always_comb begin
        aRdata_d = aRdata_q;
        bRdata_d = bRdata_q;
        if (serveA) begin
            if (aIsRead) begin
                aRdata_d = sram_rdata_i;
            end
        end else begin
            bRdata_d = sram_rdata_i;
            if (mmioRdData) begin
                aRdata_d = {8'h00, rxBuf_q};
            end else if (mmioRdStat) begin
                aRdata_d = {13'b0, overrun_q, rxFull_q, uart_tx_ready_i};
            end
        end
    end

    // UART transmit: a data-register write is forwarded as a single strobe
    // only if the transmitter is idle; otherwise the byte is dropped.
    always_comb begin
        txValid_d = mmioWrData && uart_tx_ready_i;
        txData_d  = txData_q;
        if (txValid_d) begin
            txData_d = a_wdata_i[7:0];
        end
    end

    // UART receive buffer. A read of the data register in the same cycle as
    // a new byte frees the slot, so the new byte is taken without overrun.
    // A status read clears overrun, but a fresh overrun in that same cycle
    // still sets it so the event is not lost.
    always_comb begin
        rxBuf_d   = rxBuf_q;
        rxFull_d  = rxFull_q;
        overrun_d = overrun_q;
        if (mmioRdStat) begin
            overrun_d = 1'b0;
        end
        if (uart_rx_valid_i) begin
            if (!rxFull_q || mmioRdData) begin
                rxBuf_d  = uart_rx_data_i;
                rxFull_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (mmioRdData) begin
            rxFull_d = 1'b0;
        end
    end

    // State and datapath registers, all with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FETCH;
            aRdata_q  <= 16'h0000;
            bRdata_q  <= 16'h0000;
            txValid_q <= 1'b0;
            txData_q  <= 8'h00;
            rxBuf_q   <= 8'h00;
            rxFull_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aRdata_q  <= aRdata_d;
            bRdata_q  <= bRdata_d;
            txValid_q <= txValid_d;
            txData_q  <= txData_d;
            rxBuf_q   <= rxBuf_d;
            rxFull_q  <= rxFull_d;
            overrun_q <= overrun_d;
        end
    end

    assign a_rdata_o       = aRdata_q;
    assign b_rdata_o       = bRdata_q;
    assign uart_tx_valid_o = txValid_q;
    assign uart_tx_data_o  = txData_q;
    assign irq_o           = rxFull_q;
    assign irq_index_o     = RX_IRQ_INDEX;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. A behavioural SRAM sits on the
// memory bus; a transaction-level reference model keeps its own copy of
// memory and of the UART receive state and predicts what each port must
// return, whether the cycle stalls, and what the UART strobes do.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam logic [15:0] MMIO_DATA = 16'hBF00;
    localparam logic [15:0] MMIO_STAT = 16'hBF01;

    logic        clk;
    logic        rst;
    logic [15:0] aAddr;
    logic [15:0] aWdata;
    logic [1:0]  aCtrl;
    logic [15:0] aRdata;
    logic [15:0] bAddr;
    logic [15:0] bRdata;
    logic        stall;
    logic [15:0] sramAddr;
    logic [15:0] sramWdata;
    logic [15:0] sramRdata;
    logic        sramCeN;
    logic        sramOeN;
    logic        sramWeN;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        irq;
    logic [3:0]  irqIndex;

    int compareCount = 0;
    int failCount    = 0;

    // Behavioural SRAM seen by the DUT
    logic [15:0] sramMem [0:65535];
    // Reference model state
    logic [15:0] refMem  [0:65535];
    logic [15:0] expA;
    logic [15:0] expB;
    logic        expTxValid;
    logic [7:0]  expTxData;
    logic        mRxFull;
    logic        mOverrun;
    logic [7:0]  mRxBuf;
    logic        mPrevStall;

    mem_responder dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .a_addr_i        (aAddr),
        .a_wdata_i       (aWdata),
        .a_ctrl_i        (aCtrl),
        .a_rdata_o       (aRdata),
        .b_addr_i        (bAddr),
        .b_rdata_o       (bRdata),
        .stall_o         (stall),
        .sram_addr_o     (sramAddr),
        .sram_wdata_o    (sramWdata),
        .sram_rdata_i    (sramRdata),
        .sram_ce_n_o     (sramCeN),
        .sram_oe_n_o     (sramOeN),
        .sram_we_n_o     (sramWeN),
        .uart_tx_data_o  (txData),
        .uart_tx_valid_o (txValid),
        .uart_tx_ready_i (txReady),
        .uart_rx_data_i  (rxData),
        .uart_rx_valid_i (rxValid),
        .irq_o           (irq),
        .irq_index_o     (irqIndex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: reads are combinational, writes land at the end of
    // a cycle in which the chip is selected with the write strobe low.
    assign sramRdata = (!sramCeN && !sramOeN) ? sramMem[sramAddr] : 16'hDEAD;

    always @(posedge clk) begin
        if (!sramCeN && !sramWeN) begin
            sramMem[sramAddr] <= sramWdata;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] got,
                               input logic [15:0] want);
        compareCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic resetModel();
        expA       = 16'h0000;
        expB       = 16'h0000;
        expTxValid = 1'b0;
        expTxData  = 8'h00;
        mRxFull    = 1'b0;
        mOverrun   = 1'b0;
        mRxBuf     = 8'h00;
        mPrevStall = 1'b0;
    endtask

    task automatic checkRegistered(input string tag);
        checkOutput({tag, " a_rdata"}, aRdata, expA);
        checkOutput({tag, " b_rdata"}, bRdata, expB);
        checkOutput({tag, " irq"}, {15'b0, irq}, {15'b0, mRxFull});
        checkOutput({tag, " tx_valid"}, {15'b0, txValid}, {15'b0, expTxValid});
        checkOutput({tag, " tx_data"}, {8'h00, txData}, {8'h00, expTxData});
    endtask

    // One CPU cycle: drive the request, check the combinational outputs,
    // advance the reference model, clock, then check registered outputs.
    task automatic applyStimulus(input logic [1:0] ctrl, input logic [15:0] addrA,
                                 input logic [15:0] wdata, input logic [15:0] addrB,
                                 input logic rxv, input logic [7:0] rxd,
                                 input logic txr, input string tag);
        logic isRd;
        logic isWr;
        logic isMmio;
        logic active;
        logic expStall;
        logic rdData;
        logic rdStat;
        aCtrl   = ctrl;
        aAddr   = addrA;
        aWdata  = wdata;
        bAddr   = addrB;
        rxValid = rxv;
        rxData  = rxd;
        txReady = txr;
        #1;
        isRd     = (ctrl == 2'b01);
        isWr     = (ctrl == 2'b10);
        isMmio   = (addrA == MMIO_DATA) || (addrA == MMIO_STAT);
        active   = !mPrevStall;
        expStall = active && (isRd || isWr) && !isMmio;
        checkOutput({tag, " stall"}, {15'b0, stall}, {15'b0, expStall});
        checkOutput({tag, " we_n"}, {15'b0, sramWeN}, {15'b0, !(expStall && isWr)});
        checkOutput({tag, " ce_n"}, {15'b0, sramCeN}, 16'h0000);

        rdData     = active && isRd && (addrA == MMIO_DATA);
        rdStat     = active && isRd && (addrA == MMIO_STAT);
        expTxValid = active && isWr && (addrA == MMIO_DATA) && txr;
        if (expTxValid) expTxData = wdata[7:0];
        if (expStall) begin
            if (isRd) expA = refMem[addrA];
            else      refMem[addrA] = wdata;
        end else begin
            expB = refMem[addrB];
            if (rdData) expA = {8'h00, mRxBuf};
            if (rdStat) expA = {13'b0, mOverrun, mRxFull, txr};
        end
        if (rdStat) mOverrun = 1'b0;
        if (rxv) begin
            if (!mRxFull || rdData) begin
                mRxBuf  = rxd;
                mRxFull = 1'b1;
            end else begin
                mOverrun = 1'b1;
            end
        end else if (rdData) begin
            mRxFull = 1'b0;
        end
        mPrevStall = expStall;

        @(posedge clk);
        #1;
        checkRegistered(tag);
    endtask

    initial begin
        logic [1:0]  rCtrl;
        logic [15:0] rAddrA;
        logic [15:0] rWdata;
        logic [15:0] rAddrB;
        int          kind;

        for (int i = 0; i < 65536; i++) begin
            sramMem[i] = 16'(i) ^ 16'h5A5A;
            refMem[i]  = 16'(i) ^ 16'h5A5A;
        end
        sramMem[16'h0010] = 16'h1234;  refMem[16'h0010] = 16'h1234;
        sramMem[16'h8000] = 16'hBEEF;  refMem[16'h8000] = 16'hBEEF;
        sramMem[16'h0011] = 16'h5678;  refMem[16'h0011] = 16'h5678;

        // Reset
        rst = 1'b1; aCtrl = 2'b00; aAddr = 16'h0; aWdata = 16'h0; bAddr = 16'h0;
        rxValid = 1'b0; rxData = 8'h00; txReady = 1'b1;
        resetModel();
        @(posedge clk);
        #1;
        checkRegistered("reset");
        checkOutput("reset ce_n", {15'b0, sramCeN}, 16'h0001);
        checkOutput("reset oe_n", {15'b0, sramOeN}, 16'h0001);
        checkOutput("reset we_n", {15'b0, sramWeN}, 16'h0001);
        checkOutput("reset stall", {15'b0, stall}, 16'h0000);
        checkOutput("irq_index", {12'b0, irqIndex}, 16'h0003);
        rst = 1'b0;

        // Plain fetch
        applyStimulus(2'b00, 16'h0000, 16'h0000, 16'h0010, 1'b0, 8'h00, 1'b1, "fetch");
        checkOutput("fetch value", bRdata, 16'h1234);

        // Data read colliding with fetch
        applyStimulus(2'b01, 16'h8000, 16'h0000, 16'h0011, 1'b0, 8'h00, 1'b1, "rd N");
        checkOutput("rd N a_rdata", aRdata, 16'hBEEF);
        applyStimulus(2'b01, 16'h8000, 16'h0000, 16'h0011, 1'b0, 8'h00, 1'b1, "rd N+1");
        checkOutput("rd N+1 b_rdata", bRdata, 16'h5678);

        // Data write, then read back
        applyStimulus(2'b10, 16'h8001, 16'hCAFE, 16'h0012, 1'b0, 8'h00, 1'b1, "wr N");
        applyStimulus(2'b10, 16'h8001, 16'hCAFE, 16'h0012, 1'b0, 8'h00, 1'b1, "wr N+1");
        applyStimulus(2'b01, 16'h8001, 16'h0000, 16'h0013, 1'b0, 8'h00, 1'b1, "rdback");
        applyStimulus(2'b01, 16'h8001, 16'h0000, 16'h0013, 1'b0, 8'h00, 1'b1, "rdback hold");
        checkOutput("rdback value", aRdata, 16'hCAFE);

        // UART receive, data read, overrun and status
        applyStimulus(2'b00, 16'h0000, 16'h0000, 16'h0001, 1'b1, 8'h41, 1'b1, "rx 41");
        checkOutput("rx irq", {15'b0, irq}, 16'h0001);
        applyStimulus(2'b01, MMIO_DATA, 16'h0000, 16'h0002, 1'b0, 8'h00, 1'b1, "rd data");
        checkOutput("rd data value", aRdata, 16'h0041);
        checkOutput("rd data irq", {15'b0, irq}, 16'h0000);
        applyStimulus(2'b00, 16'h0000, 16'h0000, 16'h0003, 1'b1, 8'h55, 1'b1, "rx 55");
        applyStimulus(2'b00, 16'h0000, 16'h0000, 16'h0004, 1'b1, 8'h66, 1'b1, "rx 66");
        applyStimulus(2'b01, MMIO_STAT, 16'h0000, 16'h0005, 1'b0, 8'h00, 1'b0, "stat 1");
        checkOutput("stat overrun set", aRdata, 16'h0006);
        applyStimulus(2'b01, MMIO_STAT, 16'h0000, 16'h0006, 1'b0, 8'h00, 1'b1, "stat 2");
        checkOutput("stat overrun clr", aRdata, 16'h0003);
        applyStimulus(2'b01, MMIO_DATA, 16'h0000, 16'h0007, 1'b1, 8'h77, 1'b1, "rd+rx");
        checkOutput("rd+rx value", aRdata, 16'h0055);

        // UART transmit with and without ready
        applyStimulus(2'b10, MMIO_DATA, 16'h0042, 16'h0008, 1'b0, 8'h00, 1'b1, "tx rdy");
        checkOutput("tx pulse", {txData, 7'b0, txValid}, 16'h4201);
        applyStimulus(2'b00, 16'h0000, 16'h0000, 16'h0009, 1'b0, 8'h00, 1'b1, "tx after");
        applyStimulus(2'b10, MMIO_DATA, 16'h0042, 16'h000A, 1'b0, 8'h00, 1'b0, "tx busy");
        applyStimulus(2'b10, MMIO_STAT, 16'h0099, 16'h000B, 1'b0, 8'h00, 1'b1, "tx stat");

        // Reset during the stall cycle of a write
        applyStimulus(2'b00, 16'h0000, 16'h0000, 16'h000C, 1'b0, 8'h00, 1'b1, "pre rst");
        aCtrl = 2'b10; aAddr = 16'h8002; aWdata = 16'h1111; bAddr = 16'h000D;
        #1;
        checkOutput("rst wr stall", {15'b0, stall}, 16'h0001);
        checkOutput("rst wr we_n", {15'b0, sramWeN}, 16'h0000);
        rst = 1'b1;
        resetModel();
        @(posedge clk);
        #1;
        checkOutput("rst edge we_n", {15'b0, sramWeN}, 16'h0001);
        checkOutput("rst edge stall", {15'b0, stall}, 16'h0000);
        checkRegistered("rst edge");
        rst = 1'b0;
        applyStimulus(2'b01, 16'h8002, 16'h0000, 16'h000D, 1'b0, 8'h00, 1'b1, "post rst");
        checkOutput("aborted write", aRdata, 16'h8002 ^ 16'h5A5A);
        applyStimulus(2'b01, 16'h8002, 16'h0000, 16'h000D, 1'b0, 8'h00, 1'b1, "post rst hold");

        // Randomized traffic; requests are held while stalled
        rCtrl = 2'b00; rAddrA = 16'h0; rWdata = 16'h0; rAddrB = 16'h0;
        for (int n = 0; n < 3000; n++) begin
            if (!mPrevStall) begin
                rCtrl  = 2'($urandom_range(0, 3));
                kind   = $urandom_range(0, 5);
                rAddrA = (kind == 0) ? MMIO_DATA :
                         (kind == 1) ? MMIO_STAT : 16'h8000 + 16'($urandom_range(0, 15));
                rWdata = 16'($urandom);
                rAddrB = ($urandom_range(0, 1) == 1) ? 16'h8000 + 16'($urandom_range(0, 15))
                                                     : 16'($urandom_range(0, 15));
            end
            applyStimulus(rCtrl, rAddrA, rWdata, rAddrB,
                          ($urandom_range(0, 5) == 0), 8'($urandom),
                          1'($urandom_range(0, 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
